ising_energy_eval: RTL and testbench

Downstream readout stage of the oscillator Ising machine. It consumes the final oscillator phases and the coupling matrix used by the solver, and quantizes each phase to a binary spin. It then serially accumulates the Ising energy E = −Σ_{i<j} J[i][j]·s_i·s_j, one matrix pair per cycle, and reports the spin vector plus energy with a one-cycle done pulse. The accumulation needs no multiplier: each product reduces to ±J.

---
 rtl/ising_energy_eval.sv | 122 ++++++++++++
 tb/tb_ising_energy_eval.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ising_energy_eval.sv
// Ising machine readout: quantizes oscillator phases to spins and serially accumulates
// E = -sum_{i<j} J[i][j]*s_i*s_j, one upper-triangle pair per cycle.
module ising_energy_eval #(
    parameter int N              = 16,
    parameter int fractionalBits = 16,
    parameter int dataWidth      = 32,
    localparam int energyWidth   = dataWidth + 2 * $clog2(N)
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic signed [dataWidth-1:0]   phases [N],
    input  logic signed [dataWidth-1:0]   couplingMatrix [N][N],
    output logic [N-1:0]                  spins,
    output logic signed [energyWidth-1:0] energy,
    output logic                          busy,
    output logic                          done
);

    localparam int IdxW = $clog2(N);
    localparam logic [IdxW-1:0] LastJ = IdxW'(N - 1);
    localparam logic [IdxW-1:0] LastI = IdxW'(N - 2);

    typedef enum logic [1:0] {StIdle, StAccum, StFinish} state_e;

    state_e                         state_q, state_d;
    logic [N-1:0]                   spins_q, spins_d;
    logic signed [energyWidth-1:0]  acc_q, acc_d;
    logic signed [energyWidth-1:0]  energy_q, energy_d;
    logic [IdxW-1:0]                i_q, i_d;
    logic [IdxW-1:0]                j_q, j_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic [N-1:0]                   quant_spins;
    logic signed [energyWidth-1:0]  term;
    logic                           unused_phase_bits;

    // Spin is -1 where the top two fraction bits differ, i.e. cos(2*pi*phase) < 0.
    always_comb begin
        quant_spins       = '0;
        unused_phase_bits = 1'b0;
        for (int k = 0; k < N; k++) begin
            quant_spins[k]    = phases[k][fractionalBits-1] ^ phases[k][fractionalBits-2];
            unused_phase_bits = unused_phase_bits ^ (^phases[k]);
        end
    end

    assign term = energyWidth'(couplingMatrix[i_q][j_q]);

    always_comb begin
        state_d  = state_q;
        spins_d  = spins_q;
        acc_d    = acc_q;
        energy_d = energy_q;
        i_d      = i_q;
        j_d      = j_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    spins_d = quant_spins;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = IdxW'(1);
                    busy_d  = 1'b1;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                // Like spins contribute -J, unlike spins +J.
                acc_d = (spins_q[i_q] == spins_q[j_q]) ? acc_q - term : acc_q + term;
                if (j_q == LastJ) begin
                    if (i_q == LastI) begin
                        state_d = StFinish;
                    end else begin
                        i_d = i_q + IdxW'(1);
                        j_d = i_q + IdxW'(2);
                    end
                end else begin
                    j_d = j_q + IdxW'(1);
                end
            end
            StFinish: begin
                energy_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            spins_q  <= '0;
            acc_q    <= '0;
            energy_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            spins_q  <= spins_d;
            acc_q    <= acc_d;
            energy_q <= energy_d;
            i_q      <= i_d;
            j_q      <= j_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign spins  = spins_q;
    assign energy = energy_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_ising_energy_eval.sv
// Scoreboard bench for ising_energy_eval: directed evaluations push expected spins/energy,
// a monitor pops and compares on every done pulse.
module tb_ising_energy_eval;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int EW = DW + 2 * $clog2(N);

    logic                  clk = 1'b0;
    logic                  n_rst;
    logic                  start;
    logic signed [DW-1:0]  phases [N];
    logic signed [DW-1:0]  couplingMatrix [N][N];
    logic [N-1:0]          spins;
    logic signed [EW-1:0]  energy;
    logic                  busy;
    logic                  done;

    typedef struct packed {
        logic [N-1:0]  s;
        logic [EW-1:0] e;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    localparam logic signed [EW-1:0] EMinus120 = -(EW'(120) <<< 16);
    localparam logic signed [EW-1:0] EPlus8    = EW'(8) <<< 16;

    ising_energy_eval #(
        .N             (N),
        .fractionalBits(16),
        .dataWidth     (DW)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .phases        (phases),
        .couplingMatrix(couplingMatrix),
        .spins         (spins),
        .energy        (energy),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (n_rst && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_spins", 64'(spins), 64'(e.s));
                chk("sb_energy", {24'b0, energy}, {24'b0, e.e});
            end
        end
    end

    task automatic set_j(input logic [DW-1:0] upper, input logic [DW-1:0] other);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                couplingMatrix[i][j] = (j > i) ? upper : other;
    endtask

    task automatic set_phases_alt();
        for (int k = 0; k < N; k++) phases[k] = (k % 2 == 1) ? 32'h0000_8000 : 32'h0;
    endtask

    task automatic set_phases_zero();
        for (int k = 0; k < N; k++) phases[k] = 32'h0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_eval(input logic [N-1:0] es, input logic [EW-1:0] ee, input string tag);
        exp_t e;
        int   cnt;
        e.s = es;
        e.e = ee;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_spins_at_accept"}, 64'(spins), 64'(es));
        wait_done(cnt);
        chk({tag, "_latency"}, 64'(cnt), 64'd121);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_low"}, 64'(done), 64'd0);
    endtask

    logic [DW-1:0] qphase [6];
    logic          qbit   [6];

    initial begin
        int   cnt;
        int   d0;
        exp_t e;

        n_rst = 1'b0;
        start = 1'b0;
        set_phases_zero();
        set_j(32'h0, 32'h0);
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_spins", 64'(spins), 64'd0);
        chk("rst_energy", {24'b0, energy}, 64'd0);
        @(negedge clk);
        n_rst = 1'b1;

        set_j(32'h0001_0000, 32'h0001_0000);
        run_eval(16'h0000, EMinus120, "all_like");

        set_phases_alt();
        run_eval(16'hAAAA, EPlus8, "alternating");

        qphase = '{32'h0000_3FFF, 32'h0000_4000, 32'h0000_BFFF,
                   32'h0000_C000, 32'hFFFF_C000, 32'h0001_8000};
        qbit   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        set_phases_zero();
        set_j(32'h0, 32'h0);
        for (int t = 0; t < 6; t++) begin
            phases[0] = qphase[t];
            run_eval({15'b0, qbit[t]}, '0, $sformatf("quant%0d", t));
        end

        set_phases_zero();
        set_j(32'h0001_0000, 32'h7FFF_FFFF);
        run_eval(16'h0000, EMinus120, "upper_only");

        // Second start mid-evaluation must be dropped.
        set_j(32'h0001_0000, 32'h0001_0000);
        set_phases_alt();
        e.s = 16'hAAAA;
        e.e = EPlus8;
        sb_q.push_back(e);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cnt);
        chk("ignore_latency", 64'(cnt), 64'd71);
        repeat (150) @(negedge clk);
        chk("ignore_single_done", 64'(done_cnt - d0), 64'd1);

        // Start held high: back-to-back evaluations every 122 cycles.
        set_phases_zero();
        e.s = 16'h0000;
        e.e = EMinus120;
        sb_q.push_back(e);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_done(cnt);
        chk("hold_first_latency", 64'(cnt), 64'd121);
        cnt = 0;
        @(negedge clk);
        cnt++;
        start = 1'b0;
        chk("hold_reaccept_busy", 64'(busy), 64'd1);
        while (!done && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("hold_period", 64'(cnt), 64'd122);
        @(negedge clk);

        // Asynchronous reset mid-evaluation.
        set_phases_alt();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_spins_loaded", 64'(spins), 64'hAAAA);
        repeat (60) @(negedge clk);
        d0 = done_cnt;
        #2;
        n_rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_spins", 64'(spins), 64'd0);
        chk("abort_energy", {24'b0, energy}, 64'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (130) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_eval(16'hAAAA, EPlus8, "after_abort");

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
